fpu_norm_sequencer: RTL and testbench

//  Multi-cycle normalization controller for the FP add/sub datapath.
//  - Accepts an unnormalized significand/exponent pair from the adder stage.
//  - Counts leading zeros through a priority-encoder sub-module.
//  - Left-shifts the significand and decrements the exponent by that count.
//  - Returns the result over a valid/ack handshake to the rounding stage.
//  - Handles the zero-result and underflow (flush-to-zero) cases.

---
 rtl/fpu_norm_pkg.sv | 18 +
 rtl/fpu_norm_sequencer_lzc.sv | 27 ++
 rtl/fpu_norm_sequencer.sv | 123 ++++++++++++
 tb/tb_fpu_norm_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the FP normalization sequencer: FSM state
// encoding and default datapath widths.
package fpu_norm_pkg;

  // Default significand, exponent and leading-zero-count widths
  localparam int SW_DEF = 26;
  localparam int EW_DEF = 8;
  localparam int CW_DEF = 5;

  // Sequencer states; encoding kept identical to the legacy 2-bit values
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_norm_sequencer_lzc.sv
// Combinational leading-zero counter with an all-zero flag.
// Counts zeros from the MSB; returns 0 when the input is all zeros.
module lzc_encoder
  import fpu_norm_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic [SW-1:0] mant,
  output logic [CW-1:0] lz,
  output logic          zero
);

  // Ascending scan: the last set bit seen is the highest one, so its
  // distance from the MSB is what remains in lz after the loop.
  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (mant[i]) begin
        lz = CW'(SW - 1 - i);
      end
    end
  end

  assign zero = ~|mant;

endmodule

// File: rtl/fpu_norm_sequencer.sv
// Multi-cycle normalization controller for the FP add/sub datapath.
// Captures an unnormalized significand/exponent pair, counts leading
// zeros, shifts and adjusts the exponent, and hands the result to the
// rounding stage over a valid/ack handshake. Zero and underflow results
// are flushed to zero with the matching flag raised.
module fpu_norm_sequencer
  import fpu_norm_pkg::*;
#(
  parameter int SW = SW_DEF,
  parameter int EW = EW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output logic          ready_o,
  input  logic [SW-1:0] mant_i,
  input  logic [EW-1:0] exp_i,
  output logic          valid_o,
  input  logic          ack_i,
  output logic [SW-1:0] mant_o,
  output logic [EW-1:0] exp_o,
  output logic [CW-1:0] lz_o,
  output logic          zero_o,
  output logic          underflow_o,
  output logic          busy_o
);

  // Common width for the unsigned lz-versus-exponent comparison
  localparam int MW = (EW > CW) ? EW : CW;

  state_t        state;
  logic [SW-1:0] mant_r;
  logic [EW-1:0] exp_r;
  logic [CW-1:0] lz_r;
  logic          zero_r;

  logic [CW-1:0] lz_w;
  logic          zero_w;
  logic          uflow_w;

  lzc_encoder #(
    .SW (SW),
    .CW (CW)
  ) u_lzc (
    .mant (mant_r),
    .lz   (lz_w),
    .zero (zero_w)
  );

  // Flush-to-zero when the shift would drive the exponent to zero or below
  assign uflow_w = MW'(lz_r) >= MW'(exp_r);

  assign busy_o = ~ready_o;

  // Sequencer FSM with capture registers and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mant_r      <= '0;
      exp_r       <= '0;
      lz_r        <= '0;
      zero_r      <= 1'b0;
      ready_o     <= 1'b1;
      valid_o     <= 1'b0;
      mant_o      <= '0;
      exp_o       <= '0;
      lz_o        <= '0;
      zero_o      <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            mant_r  <= mant_i;
            exp_r   <= exp_i;
            ready_o <= 1'b0;
            state   <= ENCODE;
          end
        end
        ENCODE: begin
          lz_r   <= lz_w;
          zero_r <= zero_w;
          state  <= SHIFT;
        end
        SHIFT: begin
          lz_o <= lz_r;
          if (zero_r) begin
            mant_o      <= '0;
            exp_o       <= '0;
            zero_o      <= 1'b1;
            underflow_o <= 1'b0;
          end else if (uflow_w) begin
            mant_o      <= '0;
            exp_o       <= '0;
            zero_o      <= 1'b0;
            underflow_o <= 1'b1;
          end else begin
            mant_o      <= mant_r << lz_r;
            exp_o       <= exp_r - EW'(lz_r);
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
          end
          valid_o <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (ack_i) begin
            valid_o     <= 1'b0;
            zero_o      <= 1'b0;
            underflow_o <= 1'b0;
            ready_o     <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_norm_sequencer.sv
// Scoreboard bench for fpu_norm_sequencer: the driver pushes the
// reference result when a request is issued, a monitor pops and compares
// whenever the DUT presents valid_o.
module tb_fpu_norm_sequencer;

  localparam int SW = 26;
  localparam int EW = 8;
  localparam int CW = 5;

  typedef struct {
    logic [SW-1:0] m;
    logic [EW-1:0] e;
    logic [CW-1:0] lz;
    logic          z;
    logic          u;
  } res_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          ready_o;
  logic [SW-1:0] mant_i;
  logic [EW-1:0] exp_i;
  logic          valid_o;
  logic          ack_i;
  logic [SW-1:0] mant_o;
  logic [EW-1:0] exp_o;
  logic [CW-1:0] lz_o;
  logic          zero_o;
  logic          underflow_o;
  logic          busy_o;

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   ack_mode = 2;  // 0 random, 1 held low, 2 held high
  res_t sb[$];

  int   last_rise = 0;
  int   prev_rise = 0;

  fpu_norm_sequencer #(
    .SW (SW),
    .EW (EW),
    .CW (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .ready_o     (ready_o),
    .mant_i      (mant_i),
    .exp_i       (exp_i),
    .valid_o     (valid_o),
    .ack_i       (ack_i),
    .mant_o      (mant_o),
    .exp_o       (exp_o),
    .lz_o        (lz_o),
    .zero_o      (zero_o),
    .underflow_o (underflow_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Consumer side: ack applied away from the sampling edge
  always @(posedge clk) begin
    #2;
    if (ack_mode == 0)      ack_i = ($urandom_range(0, 3) != 0);
    else if (ack_mode == 1) ack_i = 1'b0;
    else                    ack_i = 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: normalize by doubling until the top bit is reached
  function automatic res_t model(input logic [SW-1:0] m, input logic [EW-1:0] e);
    res_t r;
    longint unsigned v;
    int lz;
    r  = '{m: '0, e: '0, lz: '0, z: 1'b0, u: 1'b0};
    v  = longint'(m);
    lz = 0;
    if (v == 0) begin
      r.z = 1'b1;
      return r;
    end
    while (v < (longint'(1) << (SW - 1))) begin
      v = v * 2;
      lz++;
    end
    r.lz = CW'(lz);
    if (lz >= int'(e)) begin
      r.u = 1'b1;
    end else begin
      r.m = SW'(v);
      r.e = EW'(int'(e) - lz);
    end
    return r;
  endfunction

  // Monitor: pop on each new valid, then hold-check every cycle it stays up
  res_t          cur;
  bit            have_cur = 0;
  logic          valid_q  = 1'b0;
  logic [SW-1:0] last_m   = '0;
  logic [EW-1:0] last_e   = '0;
  logic [CW-1:0] last_lz  = '0;

  always @(negedge clk) begin
    if (rst) begin
      valid_q  = 1'b0;
      have_cur = 0;
      last_m   = '0;
      last_e   = '0;
      last_lz  = '0;
    end else begin
      if (valid_o) begin
        if (!valid_q) begin
          prev_rise = last_rise;
          last_rise = cyc;
          if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(valid_o), 64'd0);
            have_cur = 0;
          end else begin
            cur      = sb.pop_front();
            have_cur = 1;
            last_m   = cur.m;
            last_e   = cur.e;
            last_lz  = cur.lz;
          end
        end
        if (have_cur) begin
          chk("mant_o", 64'(mant_o), 64'(cur.m));
          chk("exp_o", 64'(exp_o), 64'(cur.e));
          chk("lz_o", 64'(lz_o), 64'(cur.lz));
          chk("zero_o", 64'(zero_o), 64'(cur.z));
          chk("underflow_o", 64'(underflow_o), 64'(cur.u));
        end
      end
      if (ready_o) begin
        chk("idle_valid", 64'(valid_o), 64'd0);
        chk("idle_flags", {62'd0, zero_o, underflow_o}, 64'd0);
        chk("idle_hold_mant", 64'(mant_o), 64'(last_m));
        chk("idle_hold_exp", 64'(exp_o), 64'(last_e));
        chk("idle_hold_lz", 64'(lz_o), 64'(last_lz));
      end
      valid_q = valid_o;
    end
  end

  // Waits for ready, presents one request for one edge, then scrambles inputs
  task automatic issue(input logic [SW-1:0] m, input logic [EW-1:0] e);
    int n = 0;
    while (!ready_o && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", 64'(ready_o), 64'd1);
      return;
    end
    mant_i  = m;
    exp_i   = e;
    start_i = 1'b1;
    sb.push_back(model(m, e));
    @(posedge clk); #1;
    start_i = 1'b0;
    mant_i  = SW'($urandom);
    exp_i   = EW'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !ready_o) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    int n;
    logic [SW-1:0] m;
    logic [EW-1:0] e;

    rst     = 1'b1;
    start_i = 1'b0;
    ack_i   = 1'b0;
    mant_i  = '0;
    exp_i   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_mant", 64'(mant_o), 64'd0);
    chk("rst_exp", 64'(exp_o), 64'd0);
    chk("rst_lz", 64'(lz_o), 64'd0);
    chk("rst_flags", {62'd0, zero_o, underflow_o}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: normal case and latency from the edge the request was driven after
    ack_mode = 2;
    issue(26'h0800000, 8'd100);
    n = 1;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t1_latency", 64'(n), 64'd3);
    drain();

    // T2..T4: directed corner cases
    issue(26'h3FFFFFF, 8'd5);
    issue(26'h0000000, 8'd77);
    issue(26'h0000001, 8'd200);
    issue(26'h0000400, 8'd15);
    issue(26'h0000400, 8'd16);
    issue(26'h2000000, 8'd0);
    drain();

    // Back-to-back with ack high: one result every 4 cycles
    issue(26'h0012345, 8'd60);
    issue(26'h1000000, 8'd9);
    drain();
    chk("throughput", 64'(last_rise - prev_rise), 64'd4);

    // T5: ack withheld, start pulses in DONE must be ignored
    ack_mode = 1;
    issue(26'h00ABCDE, 8'd50);
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_valid_seen", 64'(valid_o), 64'd1);
    for (int k = 0; k < 5; k++) begin
      start_i = 1'b1;
      mant_i  = SW'($urandom);
      exp_i   = EW'($urandom);
      @(posedge clk); #1;
      chk("t5_valid_held", 64'(valid_o), 64'd1);
      chk("t5_ready_low", 64'(ready_o), 64'd0);
    end
    start_i  = 1'b0;
    ack_mode = 2;
    @(posedge clk); #3;
    @(posedge clk); #1;
    chk("t5_ready_after_ack", 64'(ready_o), 64'd1);
    chk("t5_valid_after_ack", 64'(valid_o), 64'd0);
    drain();

    // T6: reset while in SHIFT abandons the request
    mant_i  = 26'h0003000;
    exp_i   = 8'd40;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_ready", 64'(ready_o), 64'd1);
    chk("t6_valid", 64'(valid_o), 64'd0);
    chk("t6_busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("t6_no_valid", 64'(valid_o), 64'd0);
    issue(26'h0003000, 8'd40);
    drain();

    // Randomized traffic with random ack back-pressure
    ack_mode = 0;
    for (int t = 0; t < 150; t++) begin
      m = SW'($urandom) >> $urandom_range(0, SW);
      if ($urandom_range(0, 2) == 0) e = EW'($urandom_range(0, 30));
      else                           e = EW'($urandom_range(0, 255));
      issue(m, e);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    ack_mode = 2;
    drain();

    finish_run();
  end

endmodule
